// File: rtl/sched_pkg.sv
// Shared scheduler-side types: executor FSM states, DVFS levels and
// the utilization counter width used by scheduler and DVFS controller.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } exec_state_t;

    localparam logic [1:0] LVL_FULL = 2'd0;
    localparam logic [1:0] LVL_DIV2 = 2'd1;
    localparam logic [1:0] LVL_DIV4 = 2'd2;
    localparam logic [1:0] LVL_DIV8 = 2'd3;

    localparam int UTIL_W_DEF = 32;

    // Terminal prescaler value for a level: 2^lvl - 1
    function automatic logic [2:0] lvl_mask(input logic [1:0] lvl);
        logic [2:0] m;
        m = 3'd0;
        case (lvl)
            LVL_FULL: m = 3'd0;
            LVL_DIV2: m = 3'd1;
            LVL_DIV4: m = 3'd3;
            LVL_DIV8: m = 3'd7;
            default:  m = 3'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/core_task_executor_if.sv
// Scheduler <-> core executor bundle: assignment strobe, task
// descriptor, busy/done feedback and utilization counters.
interface core_task_executor_if
    import sched_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int ID_W   = 4,
    parameter int UTIL_W = UTIL_W_DEF
);
    logic              assign_in;
    logic [LEN_W-1:0]  task_len;
    logic [ID_W-1:0]   task_id;
    logic [1:0]        dvfs_level;
    logic              core_busy;
    logic              done;
    logic [ID_W-1:0]   done_id;
    logic [UTIL_W-1:0] busy_cycles;
    logic [15:0]       task_count;

    modport master (
        output assign_in, task_len, task_id, dvfs_level,
        input  core_busy, done, done_id, busy_cycles, task_count
    );

    modport slave (
        input  assign_in, task_len, task_id, dvfs_level,
        output core_busy, done, done_id, busy_cycles, task_count
    );
endinterface

// File: rtl/dvfs_tick_gen.sv
// 3-bit prescaler: one tick every 2^level enabled cycles.
module dvfs_tick_gen
    import sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] level,
    input  logic       clear,
    input  logic       enable,
    output logic       tick
);
    logic [2:0] cnt;

    assign tick = enable && (cnt == lvl_mask(level));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 3'd0;
        else if (clear || tick)
            cnt <= 3'd0;
        else if (enable)
            cnt <= cnt + 3'd1;
    end
endmodule

// File: rtl/core_task_executor.sv
// Core-side task executor: captures a task, runs it at the DVFS rate,
// pulses done with the task ID and keeps utilization counters.
module core_task_executor
    import sched_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int ID_W   = 4,
    parameter int UTIL_W = UTIL_W_DEF
) (
    input logic clk,
    input logic rst,
    core_task_executor_if.slave bus
);
    exec_state_t       state, state_d;
    logic [LEN_W-1:0]  rem_q;
    logic [ID_W-1:0]   id_q;
    logic [1:0]        lvl_q;
    logic              busy_q, done_q;
    logic [ID_W-1:0]   done_id_q;
    logic [UTIL_W-1:0] busy_cnt;
    logic [15:0]       task_cnt;
    logic              capture, tick, last_unit;

    assign capture   = (state == IDLE) && bus.assign_in;
    assign last_unit = (rem_q == LEN_W'(1));

    dvfs_tick_gen u_tick (
        .clk    (clk),
        .rst    (rst),
        .level  (lvl_q),
        .clear  (capture),
        .enable (state == RUN),
        .tick   (tick)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (bus.assign_in) state_d = RUN;
            RUN:     if (tick && last_unit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Zero-length tasks are run as a single work unit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            id_q  <= '0;
            lvl_q <= LVL_FULL;
        end else if (capture) begin
            rem_q <= (bus.task_len == '0) ? LEN_W'(1) : bus.task_len;
            id_q  <= bus.task_id;
            lvl_q <= bus.dvfs_level;
        end else if (state == RUN && tick && !last_unit) begin
            rem_q <= rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            task_cnt  <= '0;
            busy_cnt  <= '0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_d == DONE);
            if (state_d == DONE) begin
                done_id_q <= id_q;
                task_cnt  <= task_cnt + 16'd1;
            end
            if (busy_q && !(&busy_cnt))
                busy_cnt <= busy_cnt + UTIL_W'(1);
        end
    end

    assign bus.core_busy   = busy_q;
    assign bus.done        = done_q;
    assign bus.done_id     = done_id_q;
    assign bus.busy_cycles = busy_cnt;
    assign bus.task_count  = task_cnt;
endmodule
